// File: rtl/gpu_pipe_pkg.sv
// Shared lane types, control-bundle field layout and skid-stage state encoding
// for the GPU pipeline register stages.
package gpu_pipe_pkg;

  localparam int LANE_W    = 18;
  localparam int NUM_LANES = 3;
  localparam int CTRL_W    = 15;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] lane_vec_t;

  localparam int CTRL_PCSRC      = 14;
  localparam int CTRL_REGWRITE   = 13;
  localparam int CTRL_MEMWRITE   = 12;
  localparam int CTRL_BRANCH     = 11;
  localparam int CTRL_FLAGWRITE  = 10;
  localparam int CTRL_MEMTOREG   = 9;
  localparam int CTRL_ALUSRC     = 8;
  localparam int CTRL_ALUCTRL_HI = 7;
  localparam int CTRL_ALUCTRL_LO = 4;
  localparam int CTRL_WA3_HI     = 3;
  localparam int CTRL_WA3_LO     = 0;

  // Side-effecting controls (PCSrc..FlagWrite) that a bubble must never assert.
  localparam logic [CTRL_W-1:0] CTRL_MASK_DEF = 15'h7C00;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/vec_pipe_stage_if.sv
// Upstream/downstream handshake and lane bundle of one vector pipeline stage.
// slave: the stage itself; master: whatever drives and drains it.
interface vec_pipe_stage_if
  import gpu_pipe_pkg::*;
#(
  parameter int N     = LANE_W,
  parameter int LANES = NUM_LANES,
  parameter int CTRLW = CTRL_W
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][N-1:0]     rd1_i;
  logic [LANES-1:0][N-1:0]     rd2_i;
  logic [LANES-1:0][N-1:0]     ext_i;
  logic [CTRLW-1:0]            ctrl_i;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][N-1:0]     rd1_o;
  logic [LANES-1:0][N-1:0]     rd2_o;
  logic [LANES-1:0][N-1:0]     ext_o;
  logic [CTRLW-1:0]            ctrl_o;

  modport slave (
    input  in_valid, rd1_i, rd2_i, ext_i, ctrl_i, out_ready,
    output in_ready, out_valid, rd1_o, rd2_o, ext_o, ctrl_o
  );

  modport master (
    output in_valid, rd1_i, rd2_i, ext_i, ctrl_i, out_ready,
    input  in_ready, out_valid, rd1_o, rd2_o, ext_o, ctrl_o
  );
endinterface

// File: rtl/pipe_slot.sv
// Load-enabled register holding one packed stage entry; clears asynchronously on reset.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/vec_pipe_stage.sv
// Two-entry skid-buffered vector pipeline register: one cycle input-to-output latency,
// in_ready/out_valid straight from the state register, full throughput under streaming.
module vec_pipe_stage
  import gpu_pipe_pkg::*;
#(
  parameter int               N         = LANE_W,
  parameter int               LANES     = NUM_LANES,
  parameter int               CTRLW     = CTRL_W,
  parameter logic [CTRLW-1:0] CTRL_MASK = CTRLW'(CTRL_MASK_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  vec_pipe_stage_if.slave      bus,
  output logic [1:0]           occ,
  output logic [15:0]          stall_cnt
);
  localparam int W = 3*LANES*N + CTRLW;

  stage_state_t     state, state_nxt;
  logic [W-1:0]     in_bundle, main_d, main_q, skid_q;
  logic             main_ld, skid_ld;
  logic             in_xfer, out_xfer;
  logic [CTRLW-1:0] main_ctrl;

  assign in_bundle     = {bus.rd1_i, bus.rd2_i, bus.ext_i, bus.ctrl_i};
  assign bus.in_ready  = (state != SKID);
  assign bus.out_valid = (state != EMPTY);
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign occ           = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Flush suppresses every slot load, so a squashed input never reaches a slot.
  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_bundle;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_ld   = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: begin
          unique case ({in_xfer, out_xfer})
            2'b11: main_ld = 1'b1;
            2'b10: begin
              skid_ld   = 1'b1;
              state_nxt = SKID;
            end
            2'b01: state_nxt = EMPTY;
            default: ;
          endcase
        end
        SKID: begin
          if (out_xfer) begin
            main_ld   = 1'b1;
            main_d    = skid_q;
            state_nxt = FULL;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_ld),
    .d     (in_bundle),
    .q     (skid_q)
  );

  assign {bus.rd1_o, bus.rd2_o, bus.ext_o, main_ctrl} = main_q;
  // Stale main-slot controls stay visible on a bubble, minus anything with side effects.
  assign bus.ctrl_o = bus.out_valid ? main_ctrl : (main_ctrl & ~CTRL_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_vec_pipe_stage.sv
// Directed scoreboard bench for vec_pipe_stage: the driver queues accepted entries,
// a monitor pops and compares every output transfer.
module tb_vec_pipe_stage;
  import gpu_pipe_pkg::*;

  typedef struct packed {
    logic [2:0][17:0] rd1;
    logic [2:0][17:0] rd2;
    logic [2:0][17:0] ext;
    logic [14:0]      ctrl;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  ent_t exp_q[$];

  vec_pipe_stage_if #(.N(18), .LANES(3), .CTRLW(15)) bus ();

  vec_pipe_stage #(.N(18), .LANES(3), .CTRLW(15), .CTRL_MASK(15'h7C00)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input ent_t e);
    bus.rd1_i  = e.rd1;
    bus.rd2_i  = e.rd2;
    bus.ext_i  = e.ext;
    bus.ctrl_i = e.ctrl;
  endtask

  // Offer one entry from a negedge, wait (bounded) for in_ready, then step one edge.
  task automatic send(input ent_t e);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    drive(e);
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("send_in_ready", bus.in_ready, 1);
    if (bus.in_ready) exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  function automatic ent_t mk_stream(input int i);
    ent_t e;
    e.rd1  = {18'(i*3+2), 18'(i*3+1), 18'(i*3)};
    e.rd2  = ~e.rd1;
    e.ext  = {18'(i << 8), 18'(i << 4), 18'(i ^ 18'h2AAAA)};
    e.ctrl = 15'(i * 37);
    return e;
  endfunction

  // Output-side monitor: samples mid-cycle, after the driver has settled its inputs.
  initial begin
    ent_t got, want;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !flush && bus.out_valid && bus.out_ready) begin
        got = {bus.rd1_o, bus.rd2_o, bus.ext_o, bus.ctrl_o};
        n_cmp++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_extra: got output %0h, required no output", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL scoreboard_data: got %0h required %0h", got, want);
          end
        end
      end
    end
  end

  initial begin
    ent_t a, b, c, f, s;
    int   out0;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.rd1_i     = '0;
    bus.rd2_i     = '0;
    bus.ext_i     = '0;
    bus.ctrl_i    = '0;

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_occ", occ, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_rd1", bus.rd1_o, 0);
    chk("rst_ctrl", bus.ctrl_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single pass
    bus.out_ready = 1'b1;
    a.rd1 = {18'h00000, 18'h00000, 18'h00005};
    a.rd2 = {18'h12345, 18'h0ABCD, 18'h3FFFF};
    a.ext = {18'h20000, 18'h00001, 18'h15555};
    a.ctrl = 15'h6001;
    send(a);
    chk("single_valid", bus.out_valid, 1);
    chk("single_rd1_lane0", bus.rd1_o[0], 18'h00005);
    chk("single_ctrl", bus.ctrl_o, 15'h6001);
    tick();
    chk("single_bubble_valid", bus.out_valid, 0);
    chk("single_bubble_ctrl", bus.ctrl_o, 15'h0001);
    chk("single_bubble_regwrite", bus.ctrl_o[CTRL_REGWRITE], 0);
    chk("single_occ", occ, 0);

    // Back-pressure: A then B held, counter climbs, then drain in order
    bus.out_ready = 1'b0;
    a.rd1 = {18'h3FFFF, 18'h20000, 18'h00001};
    a.rd2 = {18'h11111, 18'h22222, 18'h33333};
    a.ext = {18'h00AAA, 18'h00BBB, 18'h00CCC};
    a.ctrl = 15'h7FFF;
    b.rd1 = {18'h0F0F0, 18'h30F0F, 18'h00002};
    b.rd2 = {18'h01234, 18'h05678, 18'h09ABC};
    b.ext = {18'h3C3C3, 18'h03C3C, 18'h1E1E1};
    b.ctrl = 15'h2A5A;
    send(a);
    chk("bp_full_occ", occ, 1);
    send(b);
    chk("bp_skid_occ", occ, 2);
    chk("bp_skid_in_ready", bus.in_ready, 0);
    chk("bp_stall1", stall_cnt, 1);
    chk("bp_main_is_a", bus.rd1_o, a.rd1);
    tick();
    chk("bp_stall2", stall_cnt, 2);
    tick();
    chk("bp_stall3", stall_cnt, 3);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain_occ1", occ, 1);
    chk("bp_main_is_b", bus.rd1_o, b.rd1);
    chk("bp_stall_hold", stall_cnt, 3);
    tick();
    chk("bp_drain_occ0", occ, 0);
    chk("bp_drain_valid", bus.out_valid, 0);

    // Streaming at one entry per cycle
    out0 = n_out;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      drive(mk_stream(i));
      chk("stream_in_ready", bus.in_ready, 1);
      if (bus.in_ready) exp_q.push_back(mk_stream(i));
      if (i > 0) chk("stream_occ", occ, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stream_last_valid", bus.out_valid, 1);
    tick();
    chk("stream_end_occ", occ, 0);
    chk("stream_out_count", n_out - out0, 100);

    // Flush from FULL with an acceptable input in the same cycle
    f.rd1 = {18'h3DEAD, 18'h3BEEF, 18'h0BAD0};
    f.rd2 = '1;
    f.ext = '1;
    f.ctrl = 15'h7C00;
    bus.out_ready = 1'b0;
    send(a);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    drive(f);
    exp_q.delete();
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_full_occ", occ, 0);
    chk("flush_full_valid", bus.out_valid, 0);

    // Flush in SKID with in_valid high
    send(a);
    send(b);
    chk("flush_pre_occ", occ, 2);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    drive(f);
    exp_q.delete();
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_skid_occ", occ, 0);
    chk("flush_skid_valid", bus.out_valid, 0);
    chk("flush_skid_stall", stall_cnt, 0);
    chk("flush_skid_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_ghost", bus.out_valid, 0);
    end

    // Asynchronous reset between edges while two entries are held
    bus.out_ready = 1'b0;
    send(a);
    send(b);
    chk("arst_pre_occ", occ, 2);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_rd1", bus.rd1_o, 0);
    chk("arst_ext", bus.ext_o, 0);
    chk("arst_ctrl", bus.ctrl_o, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    c.rd1 = {18'h00C03, 18'h00C02, 18'h00C01};
    c.rd2 = {18'h2C000, 18'h1C000, 18'h0C000};
    c.ext = {18'h3FFFE, 18'h00000, 18'h3FFFF};
    c.ctrl = 15'h1234;
    send(c);
    chk("arst_first_valid", bus.out_valid, 1);
    chk("arst_first_rd1", bus.rd1_o, c.rd1);
    tick();
    chk("arst_first_drained", occ, 0);

    // Stall counter saturation
    s = mk_stream(7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    send(s);
    chk("sat_start", stall_cnt, 0);
    repeat (65534) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (70000 - 65535) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    chk("sat_drained", bus.out_valid, 0);
    chk("sat_after_release", stall_cnt, 16'hFFFF);
    chk("queue_empty", exp_q.size(), 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
